sr_cmd_sequencer: RTL and testbench

Command stage that sits directly upstream of the SR flip-flop and drives its S/R inputs. It accepts set/clear requests over a valid/ready handshake and turns each one into a registered S or R pulse of programmable width, followed by a quiet gap. It then confirms the flop's Q output against the requested value and reports done or error. By construction it never drives S and R high together, which is the latch's forbidden input combination.

---
 rtl/sr_cmd_sequencer_if.sv | 35 +++
 rtl/sr_cmd_sequencer.sv | 135 +++++++++++++
 tb/tb_sr_cmd_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sr_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// sr_cmd_sequencer_if
//   Bundles the command handshake, the S/R drive to the downstream SR flop,
//   the flop's Q feedback and the completion report of sr_cmd_sequencer.
//
//   req_valid / req_op / req_ready : set(1)/clear(0) request handshake
//   S / R                          : registered drive into the SR flop
//   q_fb                           : Q of the downstream flop (same clock)
//   done_valid / done_err          : one-cycle completion, err = timeout
//   busy                           : sequencer is not idle
//
//   master : requester side (drives requests, consumes S/R and status)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface sr_cmd_sequencer_if;
  logic req_valid;
  logic req_op;
  logic req_ready;
  logic S;
  logic R;
  logic q_fb;
  logic done_valid;
  logic done_err;
  logic busy;

  modport master (
    output req_valid, req_op, q_fb,
    input  req_ready, S, R, done_valid, done_err, busy
  );

  modport slave (
    input  req_valid, req_op, q_fb,
    output req_ready, S, R, done_valid, done_err, busy
  );
endinterface : sr_cmd_sequencer_if

// File: rtl/sr_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// sr_cmd_sequencer
//   Turns set/clear requests into a registered S or R pulse of PULSE_CYC
//   cycles, waits GAP_CYC quiet cycles, then watches q_fb for up to
//   TIMEOUT_CYC cycles and reports done (done_err=1 if Q never matched).
//   S and R are never high together.
//
//   Ports:
//     clk   : single clock, all state on posedge
//     rst_n : asynchronous active-low reset
//     bus   : sr_cmd_sequencer_if.slave (handshake, S/R, q_fb, status)
// ---------------------------------------------------------------------------
module sr_cmd_sequencer #(
  parameter int PULSE_CYC   = 2,
  parameter int GAP_CYC     = 1,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sr_cmd_sequencer_if.slave     bus
);

  localparam int MAX_PG  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_PG > TIMEOUT_CYC) ? MAX_PG : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_PULSE   = CNT_W'(PULSE_CYC);
  localparam logic [CNT_W-1:0] CNT_GAP     = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             done_valid_q, done_valid_d;
  logic             done_err_q, done_err_d;

  // NOTE: every variable assigned below gets a default first, so no path
  // through the case statement can leave a value unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    done_valid_d = 1'b0;
    done_err_d   = done_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          cnt_d   = CNT_PULSE;
          state_d = DRIVE;
        end
      end

      DRIVE: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = CNT_GAP;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      GAP: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = CNT_TIMEOUT;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      CHECK: begin
        if (bus.q_fb == op_q) begin
          state_d      = IDLE;
          done_valid_d = 1'b1;
          done_err_d   = 1'b0;
        end else if (cnt_q == CNT_ONE) begin
          state_d      = IDLE;
          done_valid_d = 1'b1;
          done_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase

    // S/R are registered from the *next* state so the pulse lines up with
    // the DRIVE cycles; one shared op bit makes S&R==1 impossible.
    s_d = (state_d == DRIVE) &&  op_d;
    r_d = (state_d == DRIVE) && !op_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= 1'b0;
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      s_q          <= s_d;
      r_q          <= r_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
    end
  end

  assign bus.S          = s_q;
  assign bus.R          = r_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_err   = done_err_q;
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);

endmodule : sr_cmd_sequencer

// File: tb/tb_sr_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sr_cmd_sequencer
//   Two sequencers: dut_a with default timing, dut_b with PULSE=1, GAP=3,
//   TIMEOUT=1. Each has a behavioural SR flop on its S/R outputs feeding
//   q_fb (optionally tied low). Expected completions are queued at the
//   handshake and popped when done_valid appears.
// ---------------------------------------------------------------------------
module tb_sr_cmd_sequencer;

  logic clk;
  logic rst_n;
  logic rv;        // request valid toward the selected DUT
  logic rop;       // request op (shared)
  logic tie_low;   // force q_fb to 0 on both DUTs
  logic sel;       // 0 = dut_a, 1 = dut_b

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic err;
    int   lat;
  } exp_t;

  exp_t sb[$];

  sr_cmd_sequencer_if ifa ();
  sr_cmd_sequencer_if ifb ();

  sr_cmd_sequencer #(.PULSE_CYC(2), .GAP_CYC(1), .TIMEOUT_CYC(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  sr_cmd_sequencer #(.PULSE_CYC(1), .GAP_CYC(3), .TIMEOUT_CYC(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  // Behavioural SR flops downstream of each DUT.
  logic qa, qb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa <= 1'b0;
      qb <= 1'b0;
    end else begin
      if (ifa.S)      qa <= 1'b1;
      else if (ifa.R) qa <= 1'b0;
      if (ifb.S)      qb <= 1'b1;
      else if (ifb.R) qb <= 1'b0;
    end
  end

  assign ifa.req_valid = rv & ~sel;
  assign ifb.req_valid = rv &  sel;
  assign ifa.req_op    = rop;
  assign ifb.req_op    = rop;
  assign ifa.q_fb      = tie_low ? 1'b0 : qa;
  assign ifb.q_fb      = tie_low ? 1'b0 : qb;

  // Selected-DUT views.
  logic s_m, r_m, rdy_m, busy_m, dv_m, de_m;
  assign s_m    = sel ? ifb.S          : ifa.S;
  assign r_m    = sel ? ifb.R          : ifa.R;
  assign rdy_m  = sel ? ifb.req_ready  : ifa.req_ready;
  assign busy_m = sel ? ifb.busy       : ifa.busy;
  assign dv_m   = sel ? ifb.done_valid : ifa.done_valid;
  assign de_m   = sel ? ifb.done_err   : ifa.done_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // S and R must never be high together, in either DUT, in any cycle.
  always @(negedge clk) begin
    check("sr_excl_a", {31'b0, ifa.S & ifa.R}, 32'd0);
    check("sr_excl_b", {31'b0, ifb.S & ifb.R}, 32'd0);
  end

  // Issue one command and follow it to completion. Cycle 1 is the first
  // cycle after the handshake edge. With hold set, req_valid stays high and
  // req_op toggles while busy, leaving the next request pending at done.
  task automatic run_cmd(input string tag, input logic op, input int pulse,
                         input logic exp_err, input int exp_lat, input bit hold);
    exp_t e;
    exp_t got;
    bit   seen;
    seen = 1'b0;
    rv   = 1'b1;
    rop  = op;
    check({tag, "_ready_at_hs"}, {31'b0, rdy_m}, 32'd1);
    tick();
    if (!hold) rv = 1'b0;
    e.err = exp_err;
    e.lat = exp_lat;
    sb.push_back(e);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (dv_m) begin
        got = sb.pop_front();
        check({tag, "_lat"}, cyc, got.lat);
        check({tag, "_err"}, {31'b0, de_m}, {31'b0, got.err});
        check({tag, "_ready_at_done"}, {31'b0, rdy_m}, 32'd1);
        seen = 1'b1;
        break;
      end
      check({tag, "_S"}, {31'b0, s_m}, {31'b0, (cyc <= pulse) &&  op});
      check({tag, "_R"}, {31'b0, r_m}, {31'b0, (cyc <= pulse) && !op});
      check({tag, "_busy"}, {31'b0, busy_m}, 32'd1);
      check({tag, "_ready"}, {31'b0, rdy_m}, 32'd0);
      if (hold) rop = ~rop;
      tick();
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no_done expected=done", tag);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rv      = 1'b0;
    rop     = 1'b0;
    tie_low = 1'b0;
    sel     = 1'b0;

    // Reset held for three cycles.
    repeat (3) tick();
    check("rst_S",     {31'b0, ifa.S},          32'd0);
    check("rst_R",     {31'b0, ifa.R},          32'd0);
    check("rst_ready", {31'b0, ifa.req_ready},  32'd1);
    check("rst_busy",  {31'b0, ifa.busy},       32'd0);
    check("rst_dv",    {31'b0, ifa.done_valid}, 32'd0);
    check("rst_de",    {31'b0, ifa.done_err},   32'd0);
    check("rst_b_ready", {31'b0, ifb.req_ready}, 32'd1);
    rst_n = 1'b1;

    // Set, then clear, on defaults with the flop model connected.
    run_cmd("set",   1'b1, 2, 1'b0, 5, 1'b0);
    run_cmd("clear", 1'b0, 2, 1'b0, 5, 1'b0);

    // Timeout: Q never rises.
    tie_low = 1'b1;
    run_cmd("tmo", 1'b1, 2, 1'b1, 12, 1'b0);
    tie_low = 1'b0;
    tick();
    check("tmo_dv_one_cycle", {31'b0, ifa.done_valid}, 32'd0);
    check("tmo_err_holds",    {31'b0, ifa.done_err},   32'd1);
    check("tmo_ready_after",  {31'b0, ifa.req_ready}, 32'd1);

    // Back-pressure with toggling op, then back-to-back accept in done cycle.
    run_cmd("bp",  1'b0, 2, 1'b0, 5, 1'b1);
    run_cmd("b2b", 1'b1, 2, 1'b0, 5, 1'b0);
    tick();

    // Asynchronous reset in the middle of DRIVE.
    rv  = 1'b1;
    rop = 1'b1;
    tick();
    rv = 1'b0;
    check("mid_S_before", {31'b0, ifa.S}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_S_async_drop", {31'b0, ifa.S},    32'd0);
    check("mid_busy_drop",    {31'b0, ifa.busy}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("mid_no_done", {31'b0, ifa.done_valid}, 32'd0);
      tick();
    end
    check("sb_empty_mid", sb.size(), 32'd0);

    // Parameter sweep on dut_b: mismatch, then a command with Q already set.
    sel     = 1'b1;
    tie_low = 1'b1;
    run_cmd("sw_mis", 1'b1, 1, 1'b1, 6, 1'b0);
    tie_low = 1'b0;
    tick();
    run_cmd("sw_match", 1'b1, 1, 1'b0, 6, 1'b0);
    tick();

    check("sb_empty_end", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sr_cmd_sequencer
